// File: rtl/addr_bus_mem_responder.sv
// rtl/addr_bus_mem_responder.sv - memory responder on a shared, multi-driver address bus
//
// Purpose: single-port word memory that accepts a read or write request when
// exactly one address-bus driver is enabled, lets the relay bus settle for
// WAIT_CYCLES+1 cycles, performs the access, and pulses ack for one cycle.
// Malformed requests (read+write together, floating or contended bus) are
// refused and recorded in a sticky bus_err flag.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   addr       - address bus as seen at the memory end
//   drv_sel    - bus driver enables {INC, PC, J, XY, M}
//   mem_read   - read request
//   mem_write  - write request
//   data_in    - write data
//   data_out   - read data, holds last read value
//   data_oe    - data_out valid (read completion cycle)
//   busy       - access in progress
//   ack        - one-cycle completion pulse
//   bus_err    - sticky protocol-error flag
//   err_clr    - synchronous clear of bus_err (a same-edge error wins)

module addr_bus_mem_responder #(
    parameter int ADDR_BUS_WIDTH = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [ADDR_BUS_WIDTH-1:0] addr,
    input  logic [4:0]                drv_sel,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_oe,
    output logic                      busy,
    output logic                      ack,
    output logic                      bus_err,
    input  logic                      err_clr
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]                cnt;
    logic [ADDR_BUS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]     lat_data;
    logic                      lat_rd;

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_BUS_WIDTH)-1];

    logic sel_onehot;
    logic req_any;
    logic req_ok;
    logic err_set;

    // A request is only honoured with exactly one bus driver enabled; any
    // request seen in IDLE that is not well formed is an error instead.
    assign sel_onehot = $onehot(drv_sel);
    assign req_any    = mem_read | mem_write;
    assign req_ok     = (mem_read ^ mem_write) & sel_onehot;
    assign err_set    = (state == ST_IDLE) & req_any & ~req_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        ack       = 1'b0;
        data_oe   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_ok) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                busy      = 1'b1;
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                busy      = 1'b1;
                ack       = 1'b1;
                data_oe   = lat_rd;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields are captured only on acceptance, so bus activity during
    // an access cannot disturb it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_rd   <= 1'b0;
            data_out <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_ok) begin
                cnt      <= WAIT_INIT;
                lat_addr <= addr;
                lat_data <= data_in;
                lat_rd   <= mem_read;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (state == ST_XFER && lat_rd) begin
                data_out <= mem[lat_addr];
            end

            if (err_set) begin
                bus_err <= 1'b1;
            end else if (err_clr) begin
                bus_err <= 1'b0;
            end
        end
    end

    // No reset on the array: contents are undefined until written. A reset
    // before the XFER exit edge has already forced state to IDLE, so the
    // cancelled write never lands.
    always_ff @(posedge clock) begin
        if (state == ST_XFER && !lat_rd) begin
            mem[lat_addr] <= lat_data;
        end
    end

endmodule

// File: tb/tb_addr_bus_mem_responder.sv
// tb/tb_addr_bus_mem_responder.sv - directed self-checking bench for addr_bus_mem_responder

module tb_addr_bus_mem_responder;

    localparam int WAIT_CYCLES = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] addr;
    logic [4:0] drv_sel;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;
    logic       ack;
    logic       bus_err;
    logic       err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    addr_bus_mem_responder #(
        .ADDR_BUS_WIDTH(8),
        .DATA_WIDTH    (8),
        .WAIT_CYCLES   (WAIT_CYCLES)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .addr     (addr),
        .drv_sel  (drv_sel),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .busy     (busy),
        .ack      (ack),
        .bus_err  (bus_err),
        .err_clr  (err_clr)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        addr      = 8'h00;
        data_in   = 8'h00;
        drv_sel   = 5'b00000;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        err_clr   = 1'b0;
    endtask

    // Entered and left just after a falling edge with the DUT idle. Inputs are
    // scrambled while busy; the access must still use the captured values.
    task automatic do_access(input string tag, input logic rd, input logic [7:0] a,
                             input logic [7:0] d, input logic [4:0] sel,
                             output logic [7:0] rdata);
        int cycles;
        addr      = a;
        data_in   = d;
        drv_sel   = sel;
        mem_read  = rd;
        mem_write = ~rd;
        @(posedge clock);
        @(negedge clock);
        check_eq({tag, " busy"}, busy, 1);
        addr      = a ^ 8'h30;
        data_in   = d ^ 8'h33;
        drv_sel   = 5'b00011;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        cycles    = 1;
        while (!ack && cycles < 20) begin
            @(negedge clock);
            cycles++;
        end
        check_eq({tag, " latency"}, cycles - 1, WAIT_CYCLES + 2);
        check_eq({tag, " data_oe"}, data_oe, rd);
        rdata = data_out;
        clear_inputs();
        @(negedge clock);
        check_eq({tag, " ack_pulse"}, ack, 0);
        check_eq({tag, " idle"}, busy, 0);
    endtask

    task automatic err_req(input string tag, input logic rd, input logic wr,
                           input logic [4:0] sel, input logic clr);
        addr      = 8'h3C;
        data_in   = 8'hEE;
        drv_sel   = sel;
        mem_read  = rd;
        mem_write = wr;
        err_clr   = clr;
        @(negedge clock);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " ack"}, ack, 0);
        check_eq({tag, " bus_err"}, bus_err, 1);
        clear_inputs();
        @(negedge clock);
        check_eq({tag, " ack_later"}, ack, 0);
        check_eq({tag, " busy_later"}, busy, 0);
    endtask

    task automatic pulse_clr(input string tag);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        check_eq({tag, " bus_err_clr"}, bus_err, 0);
    endtask

    initial begin
        logic [7:0] rd;
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst busy", busy, 0);
        check_eq("rst ack", ack, 0);
        check_eq("rst data_oe", data_oe, 0);
        check_eq("rst data_out", data_out, 0);
        check_eq("rst bus_err", bus_err, 0);
        reset_n = 1'b1;

        do_access("wr3C", 1'b0, 8'h3C, 8'hA5, 5'b00001, rd);
        do_access("rd3C", 1'b1, 8'h3C, 8'h00, 5'b01000, rd);
        check_eq("rd3C data", rd, 8'hA5);
        check_eq("hold data_out", data_out, 8'hA5);
        check_eq("hold data_oe", data_oe, 0);

        do_access("wrFF", 1'b0, 8'hFF, 8'h5A, 5'b10000, rd);
        do_access("wr00", 1'b0, 8'h00, 8'hC3, 5'b00010, rd);
        do_access("rdFF", 1'b1, 8'hFF, 8'h00, 5'b00100, rd);
        check_eq("rdFF data", rd, 8'h5A);
        do_access("rd00", 1'b1, 8'h00, 8'h00, 5'b00100, rd);
        check_eq("rd00 data", rd, 8'hC3);
        do_access("rdFF2", 1'b1, 8'hFF, 8'h00, 5'b00001, rd);
        check_eq("rdFF2 data", rd, 8'h5A);

        err_req("contend", 1'b0, 1'b1, 5'b00011, 1'b0);
        err_req("float", 1'b1, 1'b0, 5'b00000, 1'b0);
        pulse_clr("float");
        err_req("clr_vs_set", 1'b1, 1'b0, 5'b11000, 1'b1);
        pulse_clr("clr_vs_set");

        err_req("rdwr", 1'b1, 1'b1, 5'b00001, 1'b0);
        pulse_clr("rdwr");
        do_access("rd3C_after", 1'b1, 8'h3C, 8'h00, 5'b00001, rd);
        check_eq("rd3C_after data", rd, 8'hA5);

        do_access("wr20", 1'b0, 8'h20, 8'h99, 5'b00010, rd);
        do_access("wr10", 1'b0, 8'h10, 8'h11, 5'b00001, rd);
        do_access("rd10", 1'b1, 8'h10, 8'h00, 5'b00001, rd);
        check_eq("rd10 data", rd, 8'h11);
        do_access("rd20", 1'b1, 8'h20, 8'h00, 5'b00001, rd);
        check_eq("rd20 data", rd, 8'h99);
        check_eq("no stray err", bus_err, 0);

        do_access("wr40", 1'b0, 8'h40, 8'h33, 5'b00001, rd);
        err_req("pre_rst", 1'b0, 1'b1, 5'b00000, 1'b0);
        addr      = 8'h40;
        data_in   = 8'h77;
        drv_sel   = 5'b00001;
        mem_write = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("cancel busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check_eq("cancel busy", busy, 0);
        check_eq("cancel ack", ack, 0);
        check_eq("cancel data_oe", data_oe, 0);
        check_eq("cancel data_out", data_out, 0);
        check_eq("cancel bus_err", bus_err, 0);
        clear_inputs();
        repeat (3) begin
            @(negedge clock);
            check_eq("cancel no_ack", ack, 0);
        end
        reset_n = 1'b1;
        do_access("rd40", 1'b1, 8'h40, 8'h00, 5'b00001, rd);
        check_eq("rd40 data", rd, 8'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_bus_mem_responder.md
ADDR_BUS_MEM_RESPONDER -- requirements
Module: addr_bus_mem_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_BUS_WIDTH, 8, address bus width; memory depth = 2**ADDR_BUS_WIDTH words
- DATA_WIDTH, 8, memory word width
- WAIT_CYCLES, 2, extra relay-settle cycles per access (legal range 0..15)

REQ-002 The block SHALL have one clock, `clock`; reset is asynchronous and active-low, `reset_n`.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clock, input, 1, sole clock; all state updates on its rising edge
- reset_n, input, 1, asynchronous active-low reset
- addr, input, ADDR_BUS_WIDTH, shared address bus as received at the memory end
- drv_sel, input, 5, address-bus driver enables in the order {INC, PC, J, XY, M}
- mem_read, input, 1, read request
- mem_write, input, 1, write request
- data_in, input, DATA_WIDTH, write data
- data_out, output, DATA_WIDTH, read data
- data_oe, output, 1, data_out valid/drive enable
- busy, output, 1, access in progress
- ack, output, 1, one-cycle completion pulse
- bus_err, output, 1, sticky protocol-error flag
- err_clr, input, 1, synchronous clear of bus_err

Function
REQ-004 The block SHALL implement the FSM states IDLE, WAIT, XFER and ACK, with no other reachable state.

REQ-005 A request is valid in IDLE when exactly one of mem_read/mem_write is high and exactly one drv_sel bit is high; on that edge the block SHALL latch addr, data_in and the operation, load wait counter = WAIT_CYCLES, and go to WAIT.

REQ-006 In WAIT, if counter==0 the block SHALL go to XFER, otherwise decrement the counter; WAIT therefore lasts WAIT_CYCLES+1 cycles.

REQ-007 On the edge leaving XFER the block SHALL write the latched data to mem[latched addr] (write) or register mem[latched addr] into data_out (read), and go to ACK.

REQ-008 In ACK the block SHALL hold ack=1 for exactly one cycle, with data_oe=1 for a read and 0 for a write, then return to IDLE.

REQ-009 Latency: for a request accepted at edge n, ack SHALL be high in the cycle after edge n+WAIT_CYCLES+2.

REQ-010 Throughput: the next request SHALL be accepted no earlier than the edge leaving ACK; minimum spacing is WAIT_CYCLES+4 cycles.

REQ-011 busy SHALL be 1 in WAIT, XFER and ACK, and 0 in IDLE.

REQ-012 Changes on addr, data_in, drv_sel, mem_read or mem_write while busy SHALL be ignored, and the in-flight access SHALL complete unchanged.

REQ-013 When mem_read and mem_write are both high in IDLE, the block SHALL perform no access, stay in IDLE, assert no ack, and set bus_err.

REQ-014 When a request is present in IDLE and drv_sel has zero bits high (floating bus) or two or more bits high (contention), the block SHALL perform no access, stay in IDLE, and set bus_err.

REQ-015 bus_err SHALL stay set until err_clr=1 at a clock edge; if err_clr and a new error occur on the same edge, set SHALL win.

REQ-016 data_out SHALL hold its last read value when data_oe=0, and SHALL be 0 until the first read completes.

REQ-017 Addresses SHALL map directly with no aliasing or out-of-range case; the all-ones address SHALL be a normal location.

REQ-018 Memory contents SHALL not be initialised by reset and SHALL be undefined until written.

Reset
REQ-019 While reset_n=0 the block SHALL force state=IDLE, counter=0, data_out=0, data_oe=0, busy=0, ack=0 and bus_err=0, asynchronously.

REQ-020 A reset asserted before the XFER exit edge SHALL cancel the access: no memory write and no ack.

REQ-021 On reset release the block SHALL accept a request on the first rising edge with reset_n=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
- WAIT_CYCLES=2, write 0xA5 to 0x3C with drv_sel=00001 -> ack 4 cycles after accept, data_oe=0; then read 0x3C with drv_sel=01000 -> ack after 4 cycles, data_oe=1, data_out=0xA5.
- Write 0x5A to 0xFF, then read 0xFF -> data_out=0x5A; read 0x00 leaves 0xFF unchanged.
- Request with drv_sel=00011, then again with drv_sel=00000 -> each time no ack, busy stays 0, bus_err=1; err_clr pulse -> bus_err=0.
- mem_read=mem_write=1 -> no ack, bus_err=1; memory unchanged on readback.
- Write 0x11 to 0x10 accepted; addr and data_in changed to 0x20/0x22 during WAIT -> read of 0x10 returns 0x11, read of 0x20 returns the prior value.
- Write 0x77 to 0x40 (prior value 0x33), reset_n pulsed low during WAIT -> outputs at reset values, no ack; readback of 0x40 = 0x33.
